counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one WIDTH-bit loadable/incrementing counter datapath (ports ld, inc, data_in, data_out) between NREQ requesters.
- Round-robin arbitration; issues exactly one counter command per granted request; acknowledges the winner with a one-hot grant pulse.
- Optionally refuses increments at the counter's maximum value instead of letting it wrap.
- Sits between requester logic and the counter instance; the counter's data_out feeds back as cnt_value.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 3, counter width; must match the counter datapath

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  NREQ  per-requester request; held high until its gnt bit is seen
- req_ld  input  NREQ  per-requester opcode: 1 = load, 0 = increment
- req_data  input  NREQ*WIDTH  per-requester load value; slice i = bits [i*WIDTH +: WIDTH]
- cnt_value  input  WIDTH  current counter output (data_out)
- cnt_ld  output  1  counter load strobe
- cnt_inc  output  1  counter increment strobe
- cnt_data  output  WIDTH  counter load data
- gnt  output  NREQ  one-hot completion pulse to the winner
- nack  output  1  with gnt: request refused (increment at max)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs registered. Reset values: cnt_ld=0, cnt_inc=0, cnt_data=0, gnt=0, nack=0, busy=0. Reset sets state to IDLE and ptr to NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, ACK. Transitions IDLE->ISSUE (any req high), ISSUE->ACK (always), ACK->IDLE (always).
- IDLE:
  - Winner w = first set req bit searching ptr+1, ptr+2, ... modulo NREQ.
  - On the clock edge: latch w and its opcode.
  - Load: cnt_ld<=1, cnt_data<=req_data slice w.
  - Increment: cnt_inc<=1, unless refused (see Optional Feature); a refused increment issues no strobe and sets a pending-nack flag.
  - busy<=1.
- ISSUE: exactly one strobe (or none if refused) is high for this one cycle; the counter updates at the end of this cycle. On the edge: clear strobes, gnt<=one-hot(w), nack<=pending flag.
- ACK: gnt/nack high for exactly one cycle. On the edge: ptr<=w, clear gnt/nack/busy.
- Latency: req sampled at edge k -> strobe high cycle k+1 -> gnt cycle k+2 -> next arbitration no earlier than the cycle after gnt. Throughput is one operation per 3 cycles.
- Requester rule: deassert req on the edge that samples gnt. req high in the cycle after gnt is treated as a new request.
- Request dropped after being latched: the operation still completes and gnt still pulses.
- req/req_ld/req_data changes outside IDLE are ignored.
- Simultaneous requests: rotating priority only. A requester just served has lowest priority next time; no starvation, every requester served within NREQ arbitrations.
- cnt_value is sampled only in IDLE, when no command is in flight.
- Reset mid-operation: any in-flight strobe/gnt is dropped the next cycle; no gnt is issued for the aborted request.
- cnt_ld and cnt_inc are never high together; gnt is zero or one-hot.

Optional Feature:
- Macro COUNTER_ARB_OVF_GUARD_EN.
- Defined: an increment with cnt_value == 2**WIDTH-1 is refused. No cnt_inc is issued, the counter holds, and gnt pulses with nack=1. Loads are always accepted.
- Undefined: increments always issue cnt_inc, so the counter wraps max->0; nack is tied 0.

Decomposition:
- Package counter_arb_pkg: state enum (IDLE, ISSUE, ACK), OP_LD=1/OP_INC=0 constants, default NREQ/WIDTH localparams.
- One combinational sub-module rr_pick (inputs req, ptr; outputs winner index and any_req).
- FSM, strobes and overflow guard live in counter_arbiter.

Test Plan:
- Reset then single load: req[0]=1, req_ld[0]=1, data 3'h5 -> cnt_ld high 1 cycle with cnt_data=5, gnt=4'b0001 two cycles after req sample, nack=0, counter reads 5.
- All four request increments simultaneously from count 0 -> grants in order 0,1,2,3, each 3 cycles apart; counter ends at 4; never two strobes together.
- Fairness: req0 held continuously and req2 asserted -> grants alternate 0,2,0,2 after the first.
- Guard on: load 7 then increment -> no cnt_inc, gnt with nack=1, counter stays 7. Guard off: same stimulus -> cnt_inc issued, counter wraps to 0, nack=0.
- rst asserted during ISSUE -> strobes low next cycle, no gnt, ptr reset so req0 wins next.
- req1 dropped in the ISSUE cycle -> operation completes and gnt[1] still pulses.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the round-robin counter arbiter.
package counter_arb_pkg;

    localparam int unsigned NreqDefault  = 4;
    localparam int unsigned WidthDefault = 3;

    localparam logic OpLd  = 1'b1;
    localparam logic OpInc = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StAck   = 2'd2
    } state_e;

    // Index width that stays at least one bit for small requester counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick
    import counter_arb_pkg::*;
#(
    parameter int unsigned NREQ = NreqDefault,
    parameter int unsigned IdxW = idx_width(NreqDefault)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] winner,
    output logic            any_req
);

    logic [IdxW-1:0] idx;

    // Walk from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = IdxW'((int'(ptr) + off) % NREQ);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one load/increment counter between NREQ requesters.
// Define COUNTER_ARB_OVF_GUARD_EN to refuse increments at the counter maximum.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NreqDefault,
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_ld,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  cnt_ld,
    output logic                  cnt_inc,
    output logic [WIDTH-1:0]      cnt_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  nack,
    output logic                  busy
);

    localparam int unsigned IdxW = idx_width(NREQ);

    state_e          state_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] win_q;
    logic            nack_pend_q;

    logic [IdxW-1:0]  pick;
    logic             any_req;
    logic [WIDTH-1:0] pick_data;
    logic             refuse;

    rr_pick #(
        .NREQ(NREQ),
        .IdxW(IdxW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick),
        .any_req(any_req)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IdxW'(i)) begin
                pick_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef COUNTER_ARB_OVF_GUARD_EN
    assign refuse = (cnt_value == {WIDTH{1'b1}});
`else
    logic unused_cnt_value;
    assign unused_cnt_value = ^cnt_value;
    assign refuse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= IdxW'(NREQ - 1);
            win_q       <= '0;
            nack_pend_q <= 1'b0;
            cnt_ld      <= 1'b0;
            cnt_inc     <= 1'b0;
            cnt_data    <= '0;
            gnt         <= '0;
            nack        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        win_q <= pick;
                        busy  <= 1'b1;
                        if (req_ld[pick] == OpLd) begin
                            cnt_ld   <= 1'b1;
                            cnt_data <= pick_data;
                        end else if (refuse) begin
                            // Refused increment: no strobe, nack rides along with gnt.
                            nack_pend_q <= 1'b1;
                        end else begin
                            cnt_inc <= 1'b1;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_ld  <= 1'b0;
                    cnt_inc <= 1'b0;
                    gnt     <= NREQ'(1) << win_q;
                    nack    <= nack_pend_q;
                    state_q <= StAck;
                end
                StAck: begin
                    ptr_q       <= win_q;
                    gnt         <= '0;
                    nack        <= 1'b0;
                    nack_pend_q <= 1'b0;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench: directed scenarios plus random requesters against a transaction model.
module tb_counter_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 3;
    localparam int unsigned MAXV  = (1 << WIDTH) - 1;
`ifdef COUNTER_ARB_OVF_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_ld;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]      cnt_value;
    logic                  cnt_ld;
    logic                  cnt_inc;
    logic [WIDTH-1:0]      cnt_data;
    logic [NREQ-1:0]       gnt;
    logic                  nack;
    logic                  busy;

    counter_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_ld   (req_ld),
        .req_data (req_data),
        .cnt_value(cnt_value),
        .cnt_ld   (cnt_ld),
        .cnt_inc  (cnt_inc),
        .cnt_data (cnt_data),
        .gnt      (gnt),
        .nack     (nack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // The shared counter datapath the arbiter drives.
    logic [WIDTH-1:0] cnt;
    always @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (cnt_ld) cnt <= cnt_data;
        else if (cnt_inc) cnt <= cnt + 1'b1;
    end
    assign cnt_value = cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [31:0] v, input int i);
        return v[i];
    endfunction

    // Transaction-level model: an operation occupies 3 cycles after it is accepted.
    int              m_age = 0;
    int              m_ptr = NREQ - 1;
    int              m_win = 0;
    bit              m_ld, m_ref;
    logic [WIDTH-1:0] m_val, m_cnt;
    logic            e_ld, e_inc, e_nack, e_busy;
    logic [WIDTH-1:0] e_data;
    logic [NREQ-1:0] e_gnt;
    bit              e_valid = 1'b0;

    task automatic model_advance();
        if (rst) begin
            m_age = 0; m_ptr = NREQ - 1; m_cnt = '0;
            e_ld = 0; e_inc = 0; e_data = '0; e_gnt = '0; e_nack = 0; e_busy = 0;
        end else if (m_age == 0) begin
            e_ld = 0; e_inc = 0; e_gnt = '0; e_nack = 0; e_busy = 0;
            if (req != '0) begin
                for (int k = NREQ; k >= 1; k--)
                    if (bit_of(32'(req), (m_ptr + k) % NREQ)) m_win = (m_ptr + k) % NREQ;
                m_ld  = bit_of(32'(req_ld), m_win);
                m_val = req_data[m_win*WIDTH +: WIDTH];
                m_ref = !m_ld && Guard && (32'(m_cnt) == MAXV);
                e_ld  = m_ld;
                e_inc = !m_ld && !m_ref;
                if (m_ld) e_data = m_val;
                e_busy = 1;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            e_ld = 0; e_inc = 0;
            e_gnt  = NREQ'(1) << m_win;
            e_nack = m_ref;
            if (m_ld) m_cnt = m_val;
            else if (!m_ref) m_cnt = m_cnt + 1'b1;
            m_age = 2;
        end else begin
            e_gnt = '0; e_nack = 0; e_busy = 0;
            m_ptr = m_win;
            m_age = 0;
        end
    endtask

    int gq[$];
    int gq_cyc[$];
    bit gq_nack[$];
    int cyc = 0;
    int inc_seen = 0;
    bit rand_en = 1'b0;
    logic [NREQ-1:0] hold = '0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (e_valid) begin
            check_eq("cnt_ld", 32'(cnt_ld), 32'(e_ld));
            check_eq("cnt_inc", 32'(cnt_inc), 32'(e_inc));
            check_eq("cnt_data", 32'(cnt_data), 32'(e_data));
            check_eq("gnt", 32'(gnt), 32'(e_gnt));
            check_eq("nack", 32'(nack), 32'(e_nack));
            check_eq("busy", 32'(busy), 32'(e_busy));
            if (m_age == 0) check_eq("count", 32'(cnt), 32'(m_cnt));
        end
        if (cnt_inc === 1'b1) inc_seen++;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i] === 1'b1) begin
                gq.push_back(i); gq_cyc.push_back(cyc); gq_nack.push_back(nack);
            end
        model_advance();
        e_valid = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i] === 1'b1 && !hold[i]) req[i] = 1'b0;
        if (rand_en)
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && gnt[i] !== 1'b1 && $urandom_range(2) == 0) begin
                    req[i]    = 1'b1;
                    req_ld[i] = 1'($urandom_range(3) == 0);
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_grant(output int idx);
        int start;
        start = gq.size();
        for (int c = 0; c < 30 && gq.size() == start; c++) step();
        check_eq("grant_seen", 32'(gq.size() > start), 32'd1);
        idx = (gq.size() > start) ? gq[start] : -1;
    endtask

    task automatic raise(input int i, input bit ld, input logic [WIDTH-1:0] d);
        req[i] = 1'b1;
        req_ld[i] = ld;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        int w, base, inc0;
        rst = 1'b1; req = '0; req_ld = '0; req_data = '0;
        steps(3);
        rst = 1'b0;
        steps(2);

        // Single load of 5 by requester 0.
        raise(0, 1'b1, 3'h5);
        step();
        check_eq("load_strobe", 32'(cnt_ld), 32'd1);
        check_eq("load_data", 32'(cnt_data), 32'd5);
        step();
        check_eq("load_gnt", 32'(gnt), 32'b0001);
        check_eq("load_nack", 32'(nack), 32'd0);
        steps(2);
        check_eq("load_count", 32'(cnt), 32'd5);

        // Four simultaneous increments from 0.
        rst = 1'b1; step(); rst = 1'b0; step();
        base = gq.size();
        for (int i = 0; i < NREQ; i++) raise(i, 1'b0, '0);
        for (int k = 0; k < NREQ; k++) begin
            wait_grant(w);
            check_eq("all_order", 32'(w), 32'(k));
            if (k > 0 && gq.size() > base + k)
                check_eq("all_spacing", 32'(gq_cyc[base+k] - gq_cyc[base+k-1]), 32'd3);
        end
        steps(2);
        check_eq("all_count", 32'(cnt), 32'd4);

        // Fairness: two held requesters alternate.
        hold = 4'b0101;
        raise(0, 1'b0, '0);
        raise(2, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            wait_grant(w);
            check_eq("fair_order", 32'(w), (k % 2 == 0) ? 32'd0 : 32'd2);
        end
        hold = '0;
        req = '0;
        steps(6);

        // Increment at maximum.
        raise(3, 1'b1, 3'h7);
        wait_grant(w);
        steps(2);
        inc0 = inc_seen;
        raise(3, 1'b0, '0);
        wait_grant(w);
        check_eq("ovf_nack", 32'(gq_nack[gq.size()-1]), 32'(Guard));
        steps(2);
        check_eq("ovf_inc", 32'(inc_seen - inc0), Guard ? 32'd0 : 32'd1);
        check_eq("ovf_count", 32'(cnt), Guard ? 32'd7 : 32'd0);

        // Reset while a command is in ISSUE.
        raise(0, 1'b1, 3'h2);
        wait_grant(w);
        steps(2);
        raise(2, 1'b0, '0);
        step();
        check_eq("abort_inc_before", 32'(cnt_inc), 32'd1);
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
        check_eq("abort_inc", 32'(cnt_inc), 32'd0);
        check_eq("abort_ld", 32'(cnt_ld), 32'd0);
        check_eq("abort_gnt", 32'(gnt), 32'd0);
        base = gq.size();
        steps(4);
        check_eq("abort_nogrant", 32'(gq.size() - base), 32'd0);
        raise(0, 1'b0, '0);
        raise(1, 1'b0, '0);
        wait_grant(w);
        check_eq("abort_ptr", 32'(w), 32'd0);
        wait_grant(w);
        check_eq("abort_second", 32'(w), 32'd1);
        steps(2);

        // Requester 1 drops its request during ISSUE.
        raise(1, 1'b0, '0);
        step();
        req[1] = 1'b0;
        wait_grant(w);
        check_eq("drop_gnt", 32'(w), 32'd1);
        steps(2);

        // Random traffic.
        rand_en = 1'b1;
        steps(900);
        rand_en = 1'b0;
        steps(40);
        check_eq("drain_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
